// File: rtl/led_pkg.sv
// Shared types for the LED bank: channel modes and breathe sequencer states.
package led_pkg;

   typedef enum logic [1:0] {
      LED_OFF     = 2'd0,
      LED_PWM     = 2'd1,
      LED_BLINK   = 2'd2,
      LED_BREATHE = 2'd3
   } led_mode_t;

   typedef enum logic {
      BR_UP   = 1'b0,
      BR_DOWN = 1'b1
   } breathe_st_t;

endpackage

// File: rtl/led_timebase.sv
// Shared PWM timebase: prescaler, PWM step counter, frame strobe,
// blink phase and the triangular breathe level. Blink and breathe state
// only move on a frame boundary so every frame is emitted whole.
module led_timebase
   import led_pkg::*;
#(
   parameter int PWM_BITS     = 8,
   parameter int PRESCALE     = 391,
   parameter int BLINK_FRAMES = 250
) (
   input  logic                clk,
   input  logic                rst,
   output logic [PWM_BITS-1:0] pwm_cnt,
   output logic                frame,
   output logic                blink_phase,
   output logic [PWM_BITS-1:0] level
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [PW-1:0]       PRE_LAST   = PW'(PRESCALE - 1);
   localparam logic [BW-1:0]       BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [PWM_BITS-1:0] LVL_TOP    = '1;

   logic [PW-1:0]       r_pre;
   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [BW-1:0]       r_blink_cnt;
   logic                r_blink_phase;
   logic [PWM_BITS-1:0] r_level;
   breathe_st_t         r_br_st;
   logic                w_step;
   logic                w_frame;

   // A frame boundary is the step on which the PWM counter wraps.
   assign w_step  = (r_pre == PRE_LAST);
   assign w_frame = w_step && (r_pwm_cnt == LVL_TOP);

   // Prescaler and PWM step counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pre     <= '0;
         r_pwm_cnt <= '0;
      end else if (w_step) begin
         r_pre     <= '0;
         r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end else begin
         r_pre     <= r_pre + 1'b1;
      end
   end

   // Blink phase toggles after every BLINK_FRAMES whole frames; starts on.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b1;
      end else if (w_frame) begin
         if (r_blink_cnt == BLINK_LAST) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
         end
      end
   end

   // Breathe sequencer: level ramps 0 -> all-ones -> 0, one step per frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_level <= '0;
         r_br_st <= BR_UP;
      end else if (w_frame) begin
         case (r_br_st)
            BR_UP: begin
               r_level <= r_level + 1'b1;
               if (r_level == LVL_TOP - 1'b1) r_br_st <= BR_DOWN;
            end
            default: begin
               r_level <= r_level - 1'b1;
               if (r_level == {{(PWM_BITS-1){1'b0}}, 1'b1}) r_br_st <= BR_UP;
            end
         endcase
      end
   end

   assign pwm_cnt     = r_pwm_cnt;
   assign frame       = w_frame;
   assign blink_phase = r_blink_phase;
   assign level       = r_level;

endmodule

// File: rtl/led_bank.sv
// Multi-channel LED driver. Config writes land in a per-channel pending
// slot and are copied to the active slot only at a frame boundary, so a
// channel never changes mode or duty in the middle of a PWM frame.
module led_bank
   import led_pkg::*;
#(
   parameter int N_LEDS       = 4,
   parameter int PWM_BITS     = 8,
   parameter int PRESCALE     = 391,
   parameter int BLINK_FRAMES = 250,
   parameter bit ACTIVE_LOW   = 1'b0,
   localparam int CW          = (N_LEDS > 2) ? $clog2(N_LEDS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CW-1:0]       cfg_chan,
   input  logic [1:0]          cfg_mode,
   input  logic [PWM_BITS-1:0] cfg_duty,
   output logic [N_LEDS-1:0]   led,
   output logic                frame_tick
);

   localparam logic [CW:0] N_LIM = N_LEDS[CW:0];

   logic [PWM_BITS-1:0] w_pwm_cnt;
   logic                w_frame;
   logic                w_blink_phase;
   logic [PWM_BITS-1:0] w_level;
   logic [N_LEDS-1:0]   w_wr;
   logic [N_LEDS-1:0]   w_on;

   logic                r_ready;
   logic                r_frame_tick;
   logic [N_LEDS-1:0]   r_led;
   logic [N_LEDS-1:0]   r_pend_flag;
   led_mode_t           r_pend_mode [N_LEDS];
   logic [PWM_BITS-1:0] r_pend_duty [N_LEDS];
   led_mode_t           r_act_mode  [N_LEDS];
   logic [PWM_BITS-1:0] r_act_duty  [N_LEDS];

   // Effective on/off for one channel at the current PWM step.
   function automatic logic chan_on(input led_mode_t m,
                                    input logic [PWM_BITS-1:0] duty,
                                    input logic [PWM_BITS-1:0] cnt,
                                    input logic [PWM_BITS-1:0] lvl,
                                    input logic ph);
      logic [PWM_BITS-1:0] d;
      logic                en;
      d  = duty;
      en = 1'b1;
      case (m)
         LED_OFF:     en = 1'b0;
         LED_PWM:     d  = duty;
         LED_BLINK:   en = ph;
         LED_BREATHE: d  = (lvl < duty) ? lvl : duty;
         default:     en = 1'b0;
      endcase
      return en && ((d == {PWM_BITS{1'b1}}) || (cnt < d));
   endfunction

   led_timebase #(
      .PWM_BITS     (PWM_BITS),
      .PRESCALE     (PRESCALE),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) u_timebase (
      .clk         (clk),
      .rst         (rst),
      .pwm_cnt     (w_pwm_cnt),
      .frame       (w_frame),
      .blink_phase (w_blink_phase),
      .level       (w_level)
   );

   // Decode accepted writes to a one-hot channel strobe; out-of-range dropped.
   always_comb begin
      w_wr = '0;
      for (int i = 0; i < N_LEDS; i++) begin
         w_wr[i] = cfg_valid && r_ready && ({1'b0, cfg_chan} < N_LIM)
                   && (cfg_chan == CW'(i));
      end
   end

   // Pending/active config; a write coinciding with a boundary waits for the next.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ready     <= 1'b0;
         r_pend_flag <= '0;
         for (int i = 0; i < N_LEDS; i++) begin
            r_pend_mode[i] <= LED_OFF;
            r_pend_duty[i] <= '0;
            r_act_mode[i]  <= LED_OFF;
            r_act_duty[i]  <= '0;
         end
      end else begin
         r_ready <= 1'b1;
         for (int i = 0; i < N_LEDS; i++) begin
            if (w_frame && r_pend_flag[i]) begin
               r_act_mode[i]  <= r_pend_mode[i];
               r_act_duty[i]  <= r_pend_duty[i];
               r_pend_flag[i] <= 1'b0;
            end
            if (w_wr[i]) begin
               r_pend_mode[i] <= led_mode_t'(cfg_mode);
               r_pend_duty[i] <= cfg_duty;
               r_pend_flag[i] <= 1'b1;
            end
         end
      end
   end

   // Per-channel compare against the shared timebase.
   always_comb begin
      w_on = '0;
      for (int i = 0; i < N_LEDS; i++) begin
         w_on[i] = chan_on(r_act_mode[i], r_act_duty[i], w_pwm_cnt, w_level, w_blink_phase);
      end
   end

   // Registered LED drive and frame tick, both one cycle behind the compare.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_led        <= {N_LEDS{ACTIVE_LOW}};
         r_frame_tick <= 1'b0;
      end else begin
         r_led        <= w_on ^ {N_LEDS{ACTIVE_LOW}};
         r_frame_tick <= w_frame;
      end
   end

   assign cfg_ready  = r_ready;
   assign led        = r_led;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_led_bank.sv
// Bench for led_bank: two instances (4 channels active-high, 5 channels
// active-low) checked against a frame-arithmetic reference model.
module tb_led_bank;

   localparam int PRE   = 2;
   localparam int PB    = 4;
   localparam int BF    = 2;
   localparam int DMAX  = 15;
   localparam int FRAME = PRE * 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       va = 1'b0, vb = 1'b0;
   logic [1:0] cha = '0;
   logic [2:0] chb = '0;
   logic [1:0] ma = '0, mb = '0;
   logic [3:0] da = '0, db = '0;
   logic       rdy_a, rdy_b, tick_a, tick_b;
   logic [3:0] led_a;
   logic [4:0] led_b;

   led_bank #(.N_LEDS(4), .PWM_BITS(PB), .PRESCALE(PRE), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst(rst), .cfg_valid(va), .cfg_ready(rdy_a), .cfg_chan(cha),
      .cfg_mode(ma), .cfg_duty(da), .led(led_a), .frame_tick(tick_a));

   led_bank #(.N_LEDS(5), .PWM_BITS(PB), .PRESCALE(PRE), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .rst(rst), .cfg_valid(vb), .cfg_ready(rdy_b), .cfg_chan(chb),
      .cfg_mode(mb), .cfg_duty(db), .led(led_b), .frame_tick(tick_b));

   int total = 0;
   int bad   = 0;

   // Reference model state: k = cycles since the last reset edge.
   typedef struct {
      int         fr;
      logic [1:0] mode;
      logic [3:0] duty;
   } ev_t;

   ev_t        evq [2][8][$];
   logic [1:0] am [2][8];
   logic [3:0] ad [2][8];
   int         k = 0;
   bit         in_rst = 1'b1;
   logic [3:0] exp_a;
   logic [4:0] exp_b;
   logic       exp_tick, exp_rdy;

   function automatic int model_level(input int f);
      int p;
      p = f % (2 * DMAX);
      return (p <= DMAX) ? p : 2 * DMAX - p;
   endfunction

   function automatic bit model_on(input logic [1:0] mode, input logic [3:0] duty, input int s);
      int f, cnt, d, lvl;
      f   = s / FRAME;
      cnt = (s / PRE) % 16;
      d   = duty;
      case (mode)
         2'd0: return 1'b0;
         2'd1: d = duty;
         2'd2: if (((f / BF) % 2) != 0) return 1'b0;
         default: begin
            lvl = model_level(f);
            if (lvl < d) d = lvl;
         end
      endcase
      return (d == DMAX) || (cnt < d);
   endfunction

   // Advance one clock, update the model from the inputs sampled at the edge.
   task automatic clk_step();
      int   fr, s, f;
      ev_t  e;
      @(posedge clk);
      if (rst) begin
         k = 0;
         in_rst = 1'b1;
         for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 8; ch++) begin
               evq[d][ch].delete();
               am[d][ch] = '0;
               ad[d][ch] = '0;
            end
      end else begin
         if (k >= 1) begin
            fr = (k + 1) / FRAME + 1;
            if (va) begin
               e.fr = fr; e.mode = ma; e.duty = da;
               evq[0][cha].push_back(e);
            end
            if (vb && chb < 5) begin
               e.fr = fr; e.mode = mb; e.duty = db;
               evq[1][chb].push_back(e);
            end
         end
         k++;
         in_rst = 1'b0;
      end
      #1;
      if (in_rst) begin
         exp_a = 4'b0000; exp_b = 5'b11111; exp_tick = 1'b0; exp_rdy = 1'b0;
      end else begin
         s = k - 1;
         f = s / FRAME;
         for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 8; ch++)
               while (evq[d][ch].size() > 0 && evq[d][ch][0].fr <= f) begin
                  am[d][ch] = evq[d][ch][0].mode;
                  ad[d][ch] = evq[d][ch][0].duty;
                  void'(evq[d][ch].pop_front());
               end
         for (int ch = 0; ch < 4; ch++) exp_a[ch] = model_on(am[0][ch], ad[0][ch], s);
         for (int ch = 0; ch < 5; ch++) exp_b[ch] = !model_on(am[1][ch], ad[1][ch], s);
         exp_tick = (k % FRAME == 0);
         exp_rdy  = 1'b1;
      end
   endtask

   task automatic wr_a(input int ch, input int mode, input int duty);
      va = 1'b1; cha = 2'(ch); ma = 2'(mode); da = 4'(duty);
      clk_step();
      va = 1'b0;
   endtask

   task automatic wr_b(input int ch, input int mode, input int duty);
      vb = 1'b1; chb = 3'(ch); mb = 2'(mode); db = 4'(duty);
      clk_step();
      vb = 1'b0;
   endtask

   // Wait for the DUT's frame_tick, bounded to a little over one frame.
   task automatic wait_tick();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < FRAME + 8 && !seen; i++) begin
         clk_step();
         if (tick_a === 1'b1) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL wait_tick: frame_tick=0 after %0d cycles, required a pulse", FRAME + 8);
      end
   endtask

   task automatic test_reset();
      int nt;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         clk_step();
         total++;
         if ({led_a, led_b, rdy_a, rdy_b} !== {4'b0000, 5'b11111, 2'b00}) begin
            bad++;
            $display("FAIL reset_hold: led_a=%b led_b=%b ready=%b%b, required 0000 11111 00",
                     led_a, led_b, rdy_a, rdy_b);
         end
      end
      rst = 1'b0;
      clk_step();
      total++;
      if ({rdy_a, rdy_b, tick_a} !== 3'b110) begin
         bad++;
         $display("FAIL reset_release: ready=%b%b tick=%b, required 11 0", rdy_a, rdy_b, tick_a);
      end
      nt = 0;
      for (int n = 2; n <= 100; n++) begin
         clk_step();
         if (tick_a === 1'b1) nt++;
         total++;
         if (tick_a !== (n % FRAME == 0) || tick_b !== (n % FRAME == 0)) begin
            bad++;
            $display("FAIL tick_period: n=%0d tick=%b%b, required %b", n, tick_a, tick_b, n % FRAME == 0);
         end
      end
      total++;
      if (nt !== 3) begin
         bad++;
         $display("FAIL tick_count: %0d ticks in 100 cycles, required 3", nt);
      end
   endtask

   task automatic test_pwm();
      int duty [3] = '{4, 15, 0};
      int want [3] = '{8, 32, 0};
      int hc;
      for (int t = 0; t < 3; t++) begin
         wait_tick();
         wr_a(1, 1, duty[t]);
         wait_tick();
         hc = 0;
         for (int j = 0; j < FRAME; j++) begin
            clk_step();
            hc += int'(led_a[1]);
            total++;
            if ({led_a, led_b, tick_a, tick_b} !== {exp_a, exp_b, exp_tick, exp_tick}) begin
               bad++;
               $display("FAIL pwm_model: k=%0d got %b %b %b%b, required %b %b %b", k,
                        led_a, led_b, tick_a, tick_b, exp_a, exp_b, exp_tick);
            end
         end
         total++;
         if (hc !== want[t]) begin
            bad++;
            $display("FAIL pwm_high: duty=%0d high=%0d cycles, required %0d", duty[t], hc, want[t]);
         end
      end
   endtask

   task automatic test_blink();
      int hc, f, want;
      wait_tick();
      wr_a(0, 2, 15);
      wait_tick();
      for (int j = 0; j < 8; j++) begin
         f  = k / FRAME;
         hc = 0;
         for (int i = 0; i < FRAME; i++) begin
            clk_step();
            hc += int'(led_a[0]);
         end
         want = (((f / BF) % 2) == 0) ? FRAME : 0;
         total++;
         if (hc !== want) begin
            bad++;
            $display("FAIL blink_frame: frame=%0d high=%0d, required %0d", f, hc, want);
         end
      end
   endtask

   task automatic test_breathe();
      int hc, f, lvl, want, peak;
      wait_tick();
      wr_a(2, 3, 15);
      wait_tick();
      for (int j = 0; j < 34; j++) begin
         f  = k / FRAME;
         hc = 0;
         for (int i = 0; i < FRAME; i++) begin
            clk_step();
            hc += int'(led_a[2]);
         end
         lvl  = model_level(f);
         want = (lvl == DMAX) ? FRAME : 2 * lvl;
         total++;
         if (hc !== want) begin
            bad++;
            $display("FAIL breathe_full: frame=%0d high=%0d, required %0d", f, hc, want);
         end
      end
      wr_a(2, 3, 8);
      wait_tick();
      peak = 0;
      for (int j = 0; j < 32; j++) begin
         f  = k / FRAME;
         hc = 0;
         for (int i = 0; i < FRAME; i++) begin
            clk_step();
            hc += int'(led_a[2]);
         end
         lvl  = model_level(f);
         want = 2 * ((lvl < 8) ? lvl : 8);
         if (hc > peak) peak = hc;
         total++;
         if (hc !== want) begin
            bad++;
            $display("FAIL breathe_cap: frame=%0d high=%0d, required %0d", f, hc, want);
         end
      end
      total++;
      if (peak !== 16) begin
         bad++;
         $display("FAIL breathe_peak: peak=%0d, required 16", peak);
      end
   endtask

   task automatic test_collisions();
      int hc;
      int want [3] = '{12, 12, 20};
      wait_tick();
      wr_a(3, 1, 2);
      wr_a(3, 1, 6);
      wait_tick();
      hc = 0;
      for (int i = 0; i < FRAME; i++) begin
         clk_step();
         hc += int'(led_a[3]);
      end
      total++;
      if (hc !== 12) begin
         bad++;
         $display("FAIL last_write_wins: high=%0d, required 12", hc);
      end
      for (int i = 0; i < 2 * FRAME && (k % FRAME) != FRAME - 1; i++) clk_step();
      wr_a(3, 1, 10);
      for (int fr = 1; fr < 3; fr++) begin
         hc = 0;
         for (int i = 0; i < FRAME; i++) begin
            clk_step();
            hc += int'(led_a[3]);
         end
         total++;
         if (hc !== want[fr]) begin
            bad++;
            $display("FAIL boundary_write: frame+%0d high=%0d, required %0d", fr, hc, want[fr]);
         end
      end
      wr_b(5, 1, 15);
      wr_b(7, 2, 15);
      wr_b(6, 3, 15);
      for (int i = 0; i < 2 * FRAME + 4; i++) begin
         clk_step();
         total++;
         if (led_b !== 5'b11111) begin
            bad++;
            $display("FAIL out_of_range: k=%0d led_b=%b, required 11111", k, led_b);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 20 * FRAME; i++) begin
         va  = ($urandom_range(0, 3) == 0);
         cha = 2'($urandom);
         ma  = 2'($urandom);
         da  = 4'($urandom);
         vb  = ($urandom_range(0, 3) == 0);
         chb = 3'($urandom);
         mb  = 2'($urandom);
         db  = 4'($urandom);
         clk_step();
         total++;
         if ({led_a, led_b, tick_a, tick_b, rdy_a, rdy_b} !==
             {exp_a, exp_b, exp_tick, exp_tick, exp_rdy, exp_rdy}) begin
            bad++;
            $display("FAIL random_model: k=%0d got %b %b %b%b %b%b, required %b %b %b %b", k,
                     led_a, led_b, tick_a, tick_b, rdy_a, rdy_b, exp_a, exp_b, exp_tick, exp_rdy);
         end
      end
      va = 1'b0;
      vb = 1'b0;
   endtask

   task automatic test_mid_reset();
      wr_a(0, 1, 15);
      wr_b(4, 1, 15);
      for (int i = 0; i < 2 * FRAME && (k % FRAME) != 13; i++) clk_step();
      wr_a(1, 1, 15);
      rst = 1'b1;
      clk_step();
      total++;
      if ({led_a, led_b, rdy_a, rdy_b} !== {4'b0000, 5'b11111, 2'b00}) begin
         bad++;
         $display("FAIL mid_reset: led_a=%b led_b=%b ready=%b%b, required 0000 11111 00",
                  led_a, led_b, rdy_a, rdy_b);
      end
      rst = 1'b0;
      for (int n = 1; n <= 70; n++) begin
         clk_step();
         total++;
         if ({led_a, led_b, tick_a, tick_b} !== {4'b0000, 5'b11111, n % FRAME == 0, n % FRAME == 0}) begin
            bad++;
            $display("FAIL after_reset: n=%0d led_a=%b led_b=%b tick=%b%b, required 0000 11111 %b",
                     n, led_a, led_b, tick_a, tick_b, n % FRAME == 0);
         end
      end
   endtask

   initial begin
      test_reset();
      test_pwm();
      test_blink();
      test_breathe();
      test_collisions();
      test_random();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running at 2 ms, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
